// File: rtl/cg_vec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cg_vec_pkg
// Description : Shared defaults, row type and row-count helper for the CG
//               double-buffered vector store.
// Revision    : 1.0 - initial release
// ============================================================================
package cg_vec_pkg;

    localparam int c_DEF_ELEMENT_WIDTH = 32;
    localparam int c_DEF_NO_OF_UNITS   = 8;
    localparam int c_DEF_MEMORY_HEIGHT = 1000;

    // One row of lanes at the default geometry
    typedef logic [c_DEF_ELEMENT_WIDTH*c_DEF_NO_OF_UNITS-1:0] row_t;

    // Rows needed to hold `total` elements: ceil(total/units), never less
    // than one row and never more than the bank can hold. 33-bit math keeps
    // the rounding add from wrapping for totals near 2^32.
    function automatic logic [31:0] rows_from_total(input logic [31:0]  total,
                                                    input int unsigned  units,
                                                    input int unsigned  height);
        logic [32:0] l_sum;
        logic [32:0] l_rows;
        l_sum  = {1'b0, total} + 33'(units) - 33'd1;
        l_rows = l_sum / 33'(units);
        if (l_rows == 33'd0) begin
            l_rows = 33'd1;
        end else if (l_rows > 33'(height)) begin
            l_rows = 33'(height);
        end
        return 32'(l_rows);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cg_vec_bank.sv
`default_nettype none
// ============================================================================
// Module      : cg_vec_bank
// Description : One vector bank: synchronous RAM, one write port and one
//               registered read port. Contents are not cleared by reset;
//               only the read register is.
// Revision    : 1.0 - initial release
// ============================================================================
module cg_vec_bank
    import cg_vec_pkg::*;
#(
    parameter int WIDTH  = c_DEF_ELEMENT_WIDTH*c_DEF_NO_OF_UNITS,
    parameter int DEPTH  = c_DEF_MEMORY_HEIGHT,
    parameter int ADDR_W = $clog2(c_DEF_MEMORY_HEIGHT)+1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Storage array write port
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Registered read port; holds its value when not reading
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/cg_vector_pingpong_store.sv
`default_nettype none
// ============================================================================
// Module      : cg_vector_pingpong_store
// Description : Double-buffered vector store. One bank is streamed out row
//               by row while the other absorbs the next iteration's vector;
//               a swap request exchanges them once the write bank is full.
//               Optional build macro CG_VEC_ITER_COUNT_EN adds a saturating
//               count of accepted swaps on iter_count.
// Revision    : 1.0 - initial release
// ============================================================================
module cg_vector_pingpong_store
    import cg_vec_pkg::*;
#(
    parameter int ELEMENT_WIDTH = c_DEF_ELEMENT_WIDTH,
    parameter int NO_OF_UNITS   = c_DEF_NO_OF_UNITS,
    parameter int MEMORY_HEIGHT = c_DEF_MEMORY_HEIGHT,
    parameter int ADDRESS_WIDTH = $clog2(MEMORY_HEIGHT)+1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [31:0]                         total,
    input  logic                                wr_en,
    input  logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] wr_data,
    input  logic                                rd_en,
    output logic [ELEMENT_WIDTH*NO_OF_UNITS-1:0] rd_data,
    output logic                                rd_valid,
    output logic                                rd_done,
    output logic                                wr_done,
    input  logic                                swap,
    output logic                                swap_err,
    output logic                                wr_ovf,
    output logic                                rd_bank
`ifdef CG_VEC_ITER_COUNT_EN
    ,
    output logic [15:0]                         iter_count
`endif
);

    localparam int                       c_ROW_W = ELEMENT_WIDTH*NO_OF_UNITS;
    localparam logic [ADDRESS_WIDTH-1:0] c_ONE   = ADDRESS_WIDTH'(1);

    logic                     r_init;
    logic [ADDRESS_WIDTH-1:0] r_rows;
    logic [ADDRESS_WIDTH-1:0] r_wr_ptr;
    logic [ADDRESS_WIDTH-1:0] r_rd_ptr;
    logic                     r_wr_full;
    logic                     r_wr_ovf;
    logic                     r_rd_bank;
    logic                     r_rd_sel;
    logic                     r_rd_valid;
    logic                     r_rd_done;
    logic                     r_wr_done;
    logic                     r_swap_err;

    logic [ADDRESS_WIDTH-1:0] w_rows_total;
    logic [ADDRESS_WIDTH-1:0] w_rows;
    logic [ADDRESS_WIDTH-1:0] w_last_idx;
    logic                     w_wr_accept;
    logic                     w_wr_last;
    logic                     w_rd_last;
    logic                     w_swap_ok;
    logic [c_ROW_W-1:0]       w_q0;
    logic [c_ROW_W-1:0]       w_q1;

    // Row count is taken from total on the first cycle out of reset (r_init)
    // so writes/reads in that cycle already see the right length.
    assign w_rows_total = ADDRESS_WIDTH'(rows_from_total(total, NO_OF_UNITS, MEMORY_HEIGHT));
    assign w_rows       = r_init ? w_rows_total : r_rows;
    assign w_last_idx   = w_rows - c_ONE;

    assign w_wr_accept  = wr_en & ~r_wr_full;
    assign w_wr_last    = w_wr_accept & (r_wr_ptr == w_last_idx);
    assign w_rd_last    = (r_rd_ptr == w_last_idx);
    // A write that completes the vector commits before the swap is judged
    assign w_swap_ok    = swap & (r_wr_full | w_wr_last);

    // Write bank is always the one not being read
    cg_vec_bank #(
        .WIDTH  (c_ROW_W),
        .DEPTH  (MEMORY_HEIGHT),
        .ADDR_W (ADDRESS_WIDTH)
    ) u_bank0 (
        .clk   (clk),
        .reset (reset),
        .we    (w_wr_accept & r_rd_bank),
        .waddr (r_wr_ptr),
        .wdata (wr_data),
        .re    (rd_en & ~r_rd_bank),
        .raddr (r_rd_ptr),
        .rdata (w_q0)
    );

    cg_vec_bank #(
        .WIDTH  (c_ROW_W),
        .DEPTH  (MEMORY_HEIGHT),
        .ADDR_W (ADDRESS_WIDTH)
    ) u_bank1 (
        .clk   (clk),
        .reset (reset),
        .we    (w_wr_accept & ~r_rd_bank),
        .waddr (r_wr_ptr),
        .wdata (wr_data),
        .re    (rd_en & r_rd_bank),
        .raddr (r_rd_ptr),
        .rdata (w_q1)
    );

    // Row count register: loaded after reset and on every accepted swap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_init <= 1'b1;
            r_rows <= c_ONE;
        end else begin
            r_init <= 1'b0;
            r_rows <= w_swap_ok ? w_rows_total : w_rows;
        end
    end

    // Pointers, bank select and full/overflow flags; a swap overrides all
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_wr_full <= 1'b0;
            r_wr_ovf  <= 1'b0;
            r_rd_bank <= 1'b0;
        end else if (w_swap_ok) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_wr_full <= 1'b0;
            r_wr_ovf  <= 1'b0;
            r_rd_bank <= ~r_rd_bank;
        end else begin
            if (w_wr_accept) begin
                if (w_wr_last) begin
                    r_wr_full <= 1'b1;
                end else begin
                    r_wr_ptr <= r_wr_ptr + c_ONE;
                end
            end
            if (wr_en && r_wr_full) begin
                r_wr_ovf <= 1'b1;
            end
            if (rd_en) begin
                r_rd_ptr <= w_rd_last ? '0 : r_rd_ptr + c_ONE;
            end
        end
    end

    // One-cycle status pulses and the read-bank select for the output mux
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_valid <= 1'b0;
            r_rd_done  <= 1'b0;
            r_wr_done  <= 1'b0;
            r_swap_err <= 1'b0;
            r_rd_sel   <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            r_rd_done  <= rd_en & w_rd_last;
            r_wr_done  <= w_wr_last;
            r_swap_err <= swap & ~w_swap_ok;
            if (rd_en) begin
                r_rd_sel <= r_rd_bank;
            end
        end
    end

    assign rd_data  = r_rd_sel ? w_q1 : w_q0;
    assign rd_valid = r_rd_valid;
    assign rd_done  = r_rd_done;
    assign wr_done  = r_wr_done;
    assign swap_err = r_swap_err;
    assign wr_ovf   = r_wr_ovf;
    assign rd_bank  = r_rd_bank;

`ifdef CG_VEC_ITER_COUNT_EN
    logic [15:0] r_iter_count;

    // Saturating count of accepted swaps
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_iter_count <= '0;
        end else if (w_swap_ok && (r_iter_count != 16'hFFFF)) begin
            r_iter_count <= r_iter_count + 16'd1;
        end
    end

    assign iter_count = r_iter_count;
`endif

endmodule
`default_nettype wire
